// File: rtl/isa_pkg.sv
// Shared definitions for the ISA bus initiator.
//  - state_t : bus-cycle sequencer states
//  - cyc_t   : the four 8-bit ISA cycle types
//  - DEF_*   : default phase timing in clocks
//  - cyc_decode() : maps the CPU-side io/write bits to a cycle type
package isa_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      CMD,
      WAIT,
      HOLD,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      IOR,
      IOW,
      MEMR,
      MEMW
   } cyc_t;

   localparam int DEF_SETUP_CLKS  = 2;
   localparam int DEF_CMD_CLKS    = 6;
   localparam int DEF_HOLD_CLKS   = 2;
   localparam int DEF_RDY_TIMEOUT = 255;

   // Value returned when nobody drove the data bus (floating ISA bus reads high).
   localparam logic [7:0] RDATA_FLOAT = 8'hFF;

   function automatic cyc_t cyc_decode(input logic io, input logic write);
      cyc_t c;
      if (io) c = write ? IOW : IOR;
      else    c = write ? MEMW : MEMR;
      return c;
   endfunction

endpackage

// File: rtl/isa_cycle_timer.sv
// 8-bit loadable down-counter used to time each phase of an ISA cycle.
//  clk, reset_l     : clock, asynchronous active-low reset
//  load, load_value : load the counter (load wins over dec)
//  dec              : decrement, saturating at zero
//  zero             : counter currently holds zero
module isa_cycle_timer (
   input  logic       clk,
   input  logic       reset_l,
   input  logic       load,
   input  logic [7:0] load_value,
   input  logic       dec,
   output logic       zero
);

   logic [7:0] count_reg;

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (dec && (count_reg != 8'd0)) begin
         count_reg <= count_reg - 8'd1;
      end
   end

   assign zero = (count_reg == 8'd0);

endmodule

// File: rtl/isa_bus_master.sv
// ISA bus initiator: turns single-beat CPU requests into 8-bit ISA I/O or
// memory cycles (ADDR setup, CMD strobe, optional WAIT stretch, HOLD, DONE).
//  CPU side : cpu_req/io/write/addr/wdata in; cpu_busy, cpu_ack, cpu_rdata,
//             cpu_timeout out (all registered)
//  ISA side : bus_a, bus_d, bus_ior_l/iow_l/memr_l/memw_l, bus_aen out;
//             bus_din, bus_dir, bus_rdy in
module isa_bus_master
   import isa_pkg::*;
#(
   parameter int SETUP_CLKS  = DEF_SETUP_CLKS,
   parameter int CMD_CLKS    = DEF_CMD_CLKS,
   parameter int HOLD_CLKS   = DEF_HOLD_CLKS,
   parameter int RDY_TIMEOUT = DEF_RDY_TIMEOUT
) (
   input  logic        clk,
   input  logic        reset_l,
   input  logic        cpu_req,
   input  logic        cpu_io,
   input  logic        cpu_write,
   input  logic [19:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_busy,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_timeout,
   output logic [19:0] bus_a,
   output logic [7:0]  bus_d,
   output logic        bus_ior_l,
   output logic        bus_iow_l,
   output logic        bus_memr_l,
   output logic        bus_memw_l,
   output logic        bus_aen,
   input  logic [7:0]  bus_din,
   input  logic        bus_dir,
   input  logic        bus_rdy
);

   // Timer reload values: a phase of N clocks runs from N-1 down to zero.
   localparam logic [7:0] SETUP_LD = 8'(SETUP_CLKS - 1);
   localparam logic [7:0] CMD_LD   = 8'(CMD_CLKS - 1);
   localparam logic [7:0] HOLD_LD  = 8'(HOLD_CLKS - 1);
   localparam logic [7:0] WAIT_LD  = 8'(RDY_TIMEOUT - 1);

   state_t     state_reg;
   cyc_t       cyc_reg;
   logic       write_reg;
   logic       rdy_q;
   logic       timeout_reg;
   logic [7:0] rdata_cap;

   logic       tmr_load;
   logic [7:0] tmr_value;
   logic       tmr_dec;
   logic       tmr_zero;
   logic       strobe_end;
   logic       strobe_timeout;

   isa_cycle_timer u_timer (
      .clk        (clk),
      .reset_l    (reset_l),
      .load       (tmr_load),
      .load_value (tmr_value),
      .dec        (tmr_dec),
      .zero       (tmr_zero)
   );

   // Phase timer control and end-of-strobe detection.
   always_comb begin
      tmr_load       = 1'b0;
      tmr_value      = '0;
      tmr_dec        = 1'b0;
      strobe_end     = 1'b0;
      strobe_timeout = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cpu_req) begin
               tmr_load  = 1'b1;
               tmr_value = SETUP_LD;
            end
         end
         ADDR: begin
            if (tmr_zero) begin
               tmr_load  = 1'b1;
               tmr_value = CMD_LD;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         CMD: begin
            if (tmr_zero) begin
               tmr_load   = 1'b1;
               tmr_value  = rdy_q ? HOLD_LD : WAIT_LD;
               strobe_end = rdy_q;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         WAIT: begin
            // A ready target wins over an expiring timeout on the same clock.
            if (rdy_q || tmr_zero) begin
               tmr_load       = 1'b1;
               tmr_value      = HOLD_LD;
               strobe_end     = 1'b1;
               strobe_timeout = !rdy_q;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         HOLD: begin
            tmr_dec = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_reg   <= IDLE;
         cyc_reg     <= IOR;
         write_reg   <= 1'b0;
         rdy_q       <= 1'b0;
         timeout_reg <= 1'b0;
         rdata_cap   <= '0;
         cpu_busy    <= 1'b0;
         cpu_ack     <= 1'b0;
         cpu_rdata   <= '0;
         cpu_timeout <= 1'b0;
         bus_a       <= '0;
         bus_d       <= '0;
         bus_ior_l   <= 1'b1;
         bus_iow_l   <= 1'b1;
         bus_memr_l  <= 1'b1;
         bus_memw_l  <= 1'b1;
         bus_aen     <= 1'b1;
      end else begin
         rdy_q   <= bus_rdy;
         cpu_ack <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (cpu_req) begin
                  cyc_reg     <= cyc_decode(cpu_io, cpu_write);
                  write_reg   <= cpu_write;
                  bus_a       <= cpu_addr;
                  if (cpu_write) bus_d <= cpu_wdata;
                  bus_aen     <= 1'b0;
                  cpu_busy    <= 1'b1;
                  timeout_reg <= 1'b0;
                  state_reg   <= ADDR;
               end
            end
            ADDR: begin
               if (tmr_zero) begin
                  state_reg <= CMD;
                  case (cyc_reg)
                     IOR:     bus_ior_l  <= 1'b0;
                     IOW:     bus_iow_l  <= 1'b0;
                     MEMR:    bus_memr_l <= 1'b0;
                     default: bus_memw_l <= 1'b0;
                  endcase
               end
            end
            CMD, WAIT: begin
               if (strobe_end) begin
                  bus_ior_l   <= 1'b1;
                  bus_iow_l   <= 1'b1;
                  bus_memr_l  <= 1'b1;
                  bus_memw_l  <= 1'b1;
                  timeout_reg <= strobe_timeout;
                  // Sample read data on the last strobe-low clock; an undriven
                  // bus or an abandoned cycle reads as floating high.
                  rdata_cap   <= (strobe_timeout || !bus_dir) ? RDATA_FLOAT : bus_din;
                  state_reg   <= HOLD;
               end else if ((state_reg == CMD) && tmr_zero) begin
                  state_reg <= WAIT;
               end
            end
            HOLD: begin
               if (tmr_zero) begin
                  bus_aen   <= 1'b1;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               cpu_ack     <= 1'b1;
               cpu_busy    <= 1'b0;
               cpu_timeout <= timeout_reg;
               if (!write_reg) cpu_rdata <= rdata_cap;
               state_reg   <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_isa_bus_master.sv
module tb_isa_bus_master;

   logic        clk = 1'b0;
   logic        reset_l;
   logic        cpu_req, cpu_io, cpu_write;
   logic [19:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_busy, cpu_ack, cpu_timeout;
   logic [7:0]  cpu_rdata;
   logic [19:0] bus_a;
   logic [7:0]  bus_d;
   logic        bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen;
   logic [7:0]  bus_din;
   logic        bus_dir, bus_rdy;

   always #5 clk = ~clk;

   isa_bus_master dut (
      .clk         (clk),
      .reset_l     (reset_l),
      .cpu_req     (cpu_req),
      .cpu_io      (cpu_io),
      .cpu_write   (cpu_write),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_busy    (cpu_busy),
      .cpu_ack     (cpu_ack),
      .cpu_rdata   (cpu_rdata),
      .cpu_timeout (cpu_timeout),
      .bus_a       (bus_a),
      .bus_d       (bus_d),
      .bus_ior_l   (bus_ior_l),
      .bus_iow_l   (bus_iow_l),
      .bus_memr_l  (bus_memr_l),
      .bus_memw_l  (bus_memw_l),
      .bus_aen     (bus_aen),
      .bus_din     (bus_din),
      .bus_dir     (bus_dir),
      .bus_rdy     (bus_rdy)
   );

   // One directed transaction: stimulus plus hand-computed expectations.
   // exp_strobe: 0=ior 1=iow 2=memr 3=memw; waits>=255 means rdy stuck low.
   typedef struct {
      logic        io;
      logic        write;
      logic [19:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  din;
      logic        dir;
      int          waits;
      int          exp_strobe;
      int          exp_low;
      int          exp_lat;
      logic [7:0]  exp_rdata;
      logic        exp_to;
   } vec_t;

   vec_t vecs[7];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string tag, input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s %s: got 0x%0h expected 0x%0h", tag, name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] strobes_low();
      return {~bus_memw_l, ~bus_memr_l, ~bus_iow_l, ~bus_ior_l};
   endfunction

   task automatic run_txn(input vec_t v, input string tag);
      int lat = -1;
      int low_exp = 0, low_other = 0, overlap = 0, aen_low = 0, a_err = 0, d_err = 0;
      logic [3:0] st;
      cpu_io    = v.io;
      cpu_write = v.write;
      cpu_addr  = v.addr;
      cpu_wdata = v.wdata;
      bus_din   = v.din;
      bus_dir   = v.dir;
      bus_rdy   = (v.waits == 0);
      cpu_req   = 1'b1;
      tick();
      cpu_req   = 1'b0;
      check(tag, "busy_after_accept", int'(cpu_busy), 1);
      for (int k = 0; k < 400; k++) begin
         st = strobes_low();
         if (cpu_ack) begin
            lat = k;
            break;
         end
         for (int s = 0; s < 4; s++)
            if (st[s]) begin
               if (s == v.exp_strobe) low_exp++;
               else low_other++;
            end
         if ($countones(st) > 1) overlap++;
         if ((st != 4'b0) && bus_aen) overlap++;
         if (!bus_aen) begin
            aen_low++;
            if (bus_a != v.addr) a_err++;
            if (v.write && (bus_d != v.wdata)) d_err++;
         end
         // rdy then reaches rdy_q for the (waits+1)-th decision edge.
         if ((v.waits < 255) && (k == 6 + v.waits)) bus_rdy = 1'b1;
         tick();
      end
      check(tag, "ack_latency", lat, v.exp_lat);
      check(tag, "strobe_low_clks", low_exp, v.exp_low);
      check(tag, "wrong_strobe_clks", low_other, 0);
      check(tag, "overlap_or_unowned", overlap, 0);
      check(tag, "aen_low_clks", aen_low, v.exp_lat - 1);
      check(tag, "addr_errors", a_err, 0);
      check(tag, "data_errors", d_err, 0);
      check(tag, "rdata", int'(cpu_rdata), int'(v.exp_rdata));
      check(tag, "timeout", int'(cpu_timeout), int'(v.exp_to));
      check(tag, "busy_at_ack", int'(cpu_busy), 0);
      bus_rdy = 1'b1;
   endtask

   initial begin
      vec_t v;
      int   acks, first_lat, a_err;

      //          io    wr    addr       wdata  din    dir  wt  stb low lat rdata  to
      vecs[0] = '{1'b1, 1'b1, 20'h003D8, 8'h29, 8'h00, 1'b0, 0,  1, 6,  11, 8'h00, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 20'hB8000, 8'h00, 8'h41, 1'b1, 5,  2, 11, 16, 8'h41, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 20'h003DA, 8'h00, 8'hF9, 1'b1, 0,  0, 6,  11, 8'hF9, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 20'hB8000, 8'h41, 8'h77, 1'b1, 2,  3, 8,  13, 8'hF9, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 20'hB8001, 8'h00, 8'h55, 1'b0, 0,  2, 6,  11, 8'hFF, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 20'h003DA, 8'h00, 8'h12, 1'b1, 255, 0, 261, 266, 8'hFF, 1'b1};
      vecs[6] = '{1'b1, 1'b1, 20'h003D9, 8'h0A, 8'h00, 1'b0, 1,  1, 7,  12, 8'hFF, 1'b0};

      reset_l   = 1'b0;
      cpu_req   = 1'b0;
      cpu_io    = 1'b0;
      cpu_write = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      bus_din   = '0;
      bus_dir   = 1'b0;
      bus_rdy   = 1'b1;
      tick();
      tick();
      check("reset", "strobes", int'({bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l}), 'hF);
      check("reset", "aen", int'(bus_aen), 1);
      check("reset", "bus_a", int'(bus_a), 0);
      check("reset", "bus_d", int'(bus_d), 0);
      check("reset", "busy_ack_to", int'({cpu_busy, cpu_ack, cpu_timeout}), 0);
      check("reset", "rdata", int'(cpu_rdata), 0);
      reset_l = 1'b1;
      tick();
      tick();

      for (int i = 0; i < 7; i++) begin
         run_txn(vecs[i], $sformatf("vec%0d", i));
         $display("vec%0d io=%0b wr=%0b addr=%05h waits=%0d -> rdata=%02h timeout=%0b",
                  i, vecs[i].io, vecs[i].write, vecs[i].addr, vecs[i].waits, cpu_rdata, cpu_timeout);
         tick();
      end

      // Requests during ADDR/CMD and on the DONE clock are dropped.
      cpu_io = 1'b1; cpu_write = 1'b1; cpu_addr = 20'h003D8; cpu_wdata = 8'h11;
      bus_rdy = 1'b1;
      cpu_req = 1'b1;
      tick();
      cpu_req = 1'b0;
      acks = 0; first_lat = -1; a_err = 0;
      for (int k = 0; k < 30; k++) begin
         if (cpu_ack) begin
            acks++;
            if (first_lat < 0) first_lat = k;
         end
         if (!bus_aen && (bus_a != 20'h003D8)) a_err++;
         cpu_req  = (k == 3) || (k == 10);
         cpu_addr = cpu_req ? 20'h12345 : 20'h003D8;
         tick();
      end
      cpu_req = 1'b0;
      check("drop", "ack_count", acks, 1);
      check("drop", "ack_latency", first_lat, 11);
      check("drop", "addr_errors", a_err, 0);
      $display("drop: acks=%0d first_lat=%0d", acks, first_lat);

      // Back-to-back: next request is presented on the ack clock.
      v = '{1'b1, 1'b0, 20'h003DA, 8'h00, 8'hF0, 1'b1, 0, 0, 6, 11, 8'hF0, 1'b0};
      run_txn(v, "b2b0");
      $display("b2b0 rdata=%02h", cpu_rdata);
      v = '{1'b0, 1'b1, 20'hB8000, 8'h5A, 8'h00, 1'b0, 0, 3, 6, 11, 8'hF0, 1'b0};
      run_txn(v, "b2b1");
      $display("b2b1 rdata=%02h", cpu_rdata);
      tick();

      // Reset asserted in the middle of the command strobe.
      cpu_io = 1'b0; cpu_write = 1'b0; cpu_addr = 20'hB8000;
      bus_din = 8'h41; bus_dir = 1'b1; bus_rdy = 1'b1;
      cpu_req = 1'b1;
      tick();
      cpu_req = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      check("rst_mid", "memr_low_before", int'(bus_memr_l), 0);
      #2 reset_l = 1'b0;
      #1;
      check("rst_mid", "strobes_async", int'({bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l}), 'hF);
      check("rst_mid", "aen_async", int'(bus_aen), 1);
      check("rst_mid", "busy_async", int'(cpu_busy), 0);
      tick();
      tick();
      reset_l = 1'b1;
      acks = 0;
      for (int k = 0; k < 20; k++) begin
         if (cpu_ack) acks++;
         tick();
      end
      check("rst_mid", "no_ack", acks, 0);
      $display("rst_mid: acks after release=%0d", acks);
      v = '{1'b0, 1'b1, 20'hB8002, 8'hC3, 8'h00, 1'b0, 0, 3, 6, 11, 8'h00, 1'b0};
      run_txn(v, "post_rst");
      $display("post_rst rdata=%02h", cpu_rdata);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
